fir_mac_sequencer: RTL and testbench

//  Read-side controller for the shifting FIR sample register file.

---
 rtl/fir_mac_sequencer_pkg.sv | 15 +
 rtl/fir_mac_sequencer_mac_unit.sv | 47 ++++
 rtl/fir_mac_sequencer.sv | 129 ++++++++++++
 tb/tb_fir_mac_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_mac_sequencer_pkg.sv
// Shared definitions for the FIR read-side sequencer: FSM encodings and width helpers.
package fir_mac_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Full-precision accumulator width: product width plus growth for LENGTH terms.
  function automatic int acc_width(input int width, input int length);
    return 2 * width + $clog2(length);
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_mac_unit.sv
// Signed multiplier feeding an accumulator with synchronous clear and enable.
// acc_sum exposes the running sum including the current product so the caller
// can capture the final result on the last tap without an extra cycle.
module fir_mac_unit
  import fir_mac_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] acc_sum
);

  logic signed [2*WIDTH-1:0] prod;
  logic        [ACC_W-1:0]   prod_ext;
  logic        [ACC_W-1:0]   acc_d;
  logic        [ACC_W-1:0]   acc_q;

  // Signed product, sign-extended to the accumulator width, plus running sum.
  always_comb begin
    prod     = $signed(a) * $signed(b);
    prod_ext = {{(ACC_W - 2*WIDTH){prod[2*WIDTH-1]}}, prod};
    acc_sum  = acc_q + prod_ext;
  end

  // Clear has priority so a new sample always starts from zero.
  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_sum;
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Read-side controller for the shifting FIR sample register file: accepts a
// sample, walks all taps through the MAC unit, and holds the result on a
// valid/ready output port.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for a sample; in_ready high, pointer parked at 0
//   MAC     | one tap per cycle, pointer 0..LENGTH-1
//   DONE    | result held on out_data until out_ready
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LENGTH = 100,
  parameter int PTR_W  = $clog2(LENGTH),
  parameter int ACC_W  = acc_width(WIDTH, LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             shift_enb,
  output logic [PTR_W-1:0] pointer,
  input  logic [WIDTH-1:0] tap_data,
  output logic [PTR_W-1:0] coef_addr,
  input  logic [WIDTH-1:0] coef_data,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LENGTH - 1);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               mac_clr, mac_en, last_tap;
  logic [ACC_W-1:0]   acc, acc_sum;

  // in_data feeds the register file directly; it is not used here.
  logic unused_in_data;
  assign unused_in_data = ^{in_data, acc};

  assign last_tap = (ptr_q == PTR_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_MAC;
      ST_MAC:  if (last_tap)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Handshake and MAC control outputs; in_ready is forced low during reset.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !rst;
    shift_enb = in_valid && in_ready;
    mac_clr   = shift_enb;
    mac_en    = (state_q == ST_MAC);
  end

  // Pointer and output register next values.
  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: ptr_d = '0;
      ST_MAC: begin
        if (last_tap) begin
          ptr_d       = '0;
          out_data_d  = acc_sum;
          out_valid_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_DONE: if (out_ready) out_valid_d = 1'b0;
      default: begin
        ptr_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Pointer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  fir_mac_unit #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (mac_clr),
    .en      (mac_en),
    .a       (tap_data),
    .b       (coef_data),
    .acc     (acc),
    .acc_sum (acc_sum)
  );

  assign pointer   = ptr_q;
  assign coef_addr = ptr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with WIDTH=16, LENGTH=4 and a behavioural
// shifting register file plus coefficient table around it.
module tb_fir_mac_sequencer;

  localparam int WIDTH  = 16;
  localparam int LENGTH = 4;
  localparam int PTR_W  = 2;
  localparam int ACC_W  = 34;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             shift_enb;
  logic [PTR_W-1:0] pointer;
  logic [WIDTH-1:0] tap_data;
  logic [PTR_W-1:0] coef_addr;
  logic [WIDTH-1:0] coef_data;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  logic [WIDTH-1:0] regs [LENGTH];
  logic [WIDTH-1:0] coef [LENGTH];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(
    .WIDTH  (WIDTH),
    .LENGTH (LENGTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .shift_enb (shift_enb),
    .pointer   (pointer),
    .tap_data  (tap_data),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Shifting sample register file, reset by the same rst as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LENGTH; i++) regs[i] <= '0;
    end else if (shift_enb) begin
      regs[0] <= in_data;
      for (int i = 1; i < LENGTH; i++) regs[i] <= regs[i-1];
    end
  end

  assign tap_data  = regs[pointer];
  assign coef_data = coef[coef_addr];

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Offer a sample, wait for its result, check latency and value.
  task automatic send_sample(input string tag, input logic [WIDTH-1:0] s,
                             input longint exp, input bit hold_valid);
    int n;
    in_data  = s;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_rdy_wait"}, longint'(n < 50), 1);
    @(posedge clk); #1;
    if (!hold_valid) in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < LENGTH + 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, LENGTH);
    chk(tag, $signed(out_data), exp);
  endtask

  longint stream_exp [8] = '{1, 4, 10, 20, 30, 40, 50, 60};
  longint imp_exp    [4] = '{1, 2, 3, 4};
  longint ext_exp    [4] = '{64'sd1073741824, 64'sd2147483648,
                             64'sd3221225472, 64'sd4294967296};

  initial begin
    int n;
    logic [ACC_W-1:0] held;
    for (int i = 0; i < LENGTH; i++) coef[i] = WIDTH'(i + 1);
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pointer",   pointer,   0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_shift_enb", shift_enb, 0);
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_release_in_ready", in_ready, 1);

    // Reset asserted mid-MAC with in_valid still high.
    in_data = 16'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_shift_enb", shift_enb, 0);
    chk("mid_rst_pointer",   pointer,   0);
    chk("mid_rst_in_ready",  in_ready,  0);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    chk("mid_rst_release_in_ready", in_ready, 1);

    // Impulse response.
    apply_reset();
    send_sample("imp0", 16'd1, imp_exp[0], 1'b0);
    send_sample("imp1", 16'd0, imp_exp[1], 1'b0);
    send_sample("imp2", 16'd0, imp_exp[2], 1'b0);
    send_sample("imp3", 16'd0, imp_exp[3], 1'b0);

    // Most negative coefficients and samples: no wrap at 2^32.
    for (int i = 0; i < LENGTH; i++) coef[i] = 16'h8000;
    apply_reset();
    for (int i = 0; i < 4; i++) send_sample($sformatf("ext%0d", i), 16'h8000, ext_exp[i], 1'b0);
    for (int i = 0; i < LENGTH; i++) coef[i] = WIDTH'(i + 1);

    // Backpressure in DONE with in_valid held high.
    apply_reset();
    out_ready = 1'b0;
    send_sample("bp", 16'd3, 3, 1'b1);
    held = out_data;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_data",      out_data,  held);
      chk("bp_valid",     out_valid, 1);
      chk("bp_in_ready",  in_ready,  0);
      chk("bp_shift_enb", shift_enb, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid",    out_valid, 0);
    chk("bp_release_in_ready", in_ready,  1);

    // Abort at pointer 2, then restart.
    apply_reset();
    in_data = 16'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (pointer != 2'd2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_ptr_reached", pointer, 2);
    rst = 1'b1; #1;
    chk("abort_out_valid", out_valid, 0);
    @(negedge clk); rst = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("abort_no_output", n, 0);
    send_sample("abort_restart", 16'd5, 5, 1'b0);

    // Streaming with in_valid held high.
    apply_reset();
    for (int i = 0; i < 8; i++)
      send_sample($sformatf("stream%0d", i), WIDTH'(i + 1), stream_exp[i], 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_end_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
